// File: rtl/uart_serial_bridge.sv
// uart_serial_bridge
// Bridges the processor's byte-wide serial handshake to an 8N1 UART line pair.
// TX: write strobe -> TX FIFO -> shifter on uart_txd (back-to-back frames).
// RX: 2-flop synchroniser -> mid-bit sampler -> show-ahead RX FIFO.
// Every output is driven straight from a flop.

module uart_serial_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_tx_data,
    input  logic       cpu_tx_wren,
    output logic       cpu_tx_ready,
    output logic [7:0] cpu_rx_data,
    output logic       cpu_rx_valid,
    input  logic       cpu_rx_rden,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_overrun,
    output logic       rx_frame_error
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ZERO_PTR  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
    localparam logic [CLK_W-1:0] ZERO_CLK  = {CLK_W{1'b0}};
    localparam logic [CLK_W-1:0] ONE_CLK   = CLK_W'(1);
    localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_r;
    logic [PTR_W-1:0] tx_rd_ptr_r;
    logic [CNT_W-1:0] tx_count_r;
    logic [CNT_W-1:0] tx_count_next_s;
    logic             tx_ready_r;
    logic             tx_push_s;
    logic             tx_pop_s;

    assign tx_push_s = cpu_tx_wren & tx_ready_r;

    // Occupancy update: simultaneous push and pop leave the count alone.
    always_comb begin
        tx_count_next_s = tx_count_r;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_next_s = tx_count_r + ONE_CNT;
            2'b01:   tx_count_next_s = tx_count_r - ONE_CNT;
            default: tx_count_next_s = tx_count_r;
        endcase
    end

    // TX FIFO storage, pointers, count and registered ready flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_r[i] <= 8'h00;
            end
            tx_wr_ptr_r <= ZERO_PTR;
            tx_rd_ptr_r <= ZERO_PTR;
            tx_count_r  <= ZERO_CNT;
            tx_ready_r  <= 1'b1;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_ptr_r] <= cpu_tx_data;
                tx_wr_ptr_r           <= tx_wr_ptr_r + ONE_PTR;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + ONE_PTR;
            end
            tx_count_r <= tx_count_next_s;
            tx_ready_r <= (tx_count_next_s != FULL_CNT);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t        tx_state_r;
    tx_state_t        tx_state_next_s;
    logic [CLK_W-1:0] tx_clk_r;
    logic [CLK_W-1:0] tx_clk_next_s;
    logic [2:0]       tx_bit_r;
    logic [2:0]       tx_bit_next_s;
    logic [7:0]       tx_shift_r;
    logic [7:0]       tx_shift_next_s;
    logic             txd_r;
    logic             txd_next_s;
    logic             tx_fifo_has_data_s;

    assign tx_fifo_has_data_s = (tx_count_r != ZERO_CNT);

    // TX next-state: pops the FIFO head into the shifter from IDLE or at STOP end.
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_clk_next_s   = tx_clk_r + ONE_CLK;
        tx_bit_next_s   = tx_bit_r;
        tx_shift_next_s = tx_shift_r;
        tx_pop_s        = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_clk_next_s = ZERO_CLK;
                if (tx_fifo_has_data_s) begin
                    tx_pop_s        = 1'b1;
                    tx_shift_next_s = tx_mem_r[tx_rd_ptr_r];
                    tx_state_next_s = TX_START;
                end else begin
                    tx_state_next_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_clk_r == BIT_LAST) begin
                    tx_clk_next_s   = ZERO_CLK;
                    tx_bit_next_s   = 3'd0;
                    tx_state_next_s = TX_DATA;
                end else begin
                    tx_state_next_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_clk_r == BIT_LAST) begin
                    tx_clk_next_s   = ZERO_CLK;
                    tx_shift_next_s = {1'b0, tx_shift_r[7:1]};
                    if (tx_bit_r == 3'd7) begin
                        tx_state_next_s = TX_STOP;
                    end else begin
                        tx_bit_next_s = tx_bit_r + 3'd1;
                    end
                end else begin
                    tx_state_next_s = TX_DATA;
                end
            end
            TX_STOP: begin
                if (tx_clk_r == BIT_LAST) begin
                    tx_clk_next_s = ZERO_CLK;
                    // Chain straight into the next frame when more data waits.
                    if (tx_fifo_has_data_s) begin
                        tx_pop_s        = 1'b1;
                        tx_shift_next_s = tx_mem_r[tx_rd_ptr_r];
                        tx_state_next_s = TX_START;
                    end else begin
                        tx_state_next_s = TX_IDLE;
                    end
                end else begin
                    tx_state_next_s = TX_STOP;
                end
            end
            default: begin
                tx_clk_next_s   = ZERO_CLK;
                tx_state_next_s = TX_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered so uart_txd is a plain flop.
    always_comb begin
        txd_next_s = 1'b1;
        case (tx_state_next_s)
            TX_START: txd_next_s = 1'b0;
            TX_DATA:  txd_next_s = tx_shift_next_s[0];
            default:  txd_next_s = 1'b1;
        endcase
    end

    // TX FSM state, counters, shifter and line register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_clk_r   <= ZERO_CLK;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_clk_r   <= tx_clk_next_s;
            tx_bit_r   <= tx_bit_next_s;
            tx_shift_r <= tx_shift_next_s;
            txd_r      <= txd_next_s;
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser
    // ------------------------------------------------------------------
    logic rx_sync1_r;
    logic rx_sync2_r;
    logic rx_line_s;

    // Two-flop synchroniser for the asynchronous receive line (idles high).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
        end else begin
            rx_sync1_r <= uart_rxd;
            rx_sync2_r <= rx_sync1_r;
        end
    end

    assign rx_line_s = rx_sync2_r;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state_r;
    rx_state_t        rx_state_next_s;
    logic [CLK_W-1:0] rx_clk_r;
    logic [CLK_W-1:0] rx_clk_next_s;
    logic [2:0]       rx_bit_r;
    logic [2:0]       rx_bit_next_s;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_shift_next_s;
    logic             rx_push_s;
    logic             rx_pop_s;
    logic             rx_full_s;
    logic             rx_frame_error_r;
    logic             rx_frame_error_next_s;
    logic             rx_overrun_r;
    logic             rx_overrun_set_s;
    logic [CNT_W-1:0] rx_count_r;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign rx_pop_s  = cpu_rx_rden & (rx_count_r != ZERO_CNT);
    assign rx_full_s = (rx_count_r == FULL_CNT) & ~rx_pop_s;

    // RX next-state: half-bit start check, then one sample per bit period.
    always_comb begin
        rx_state_next_s       = rx_state_r;
        rx_clk_next_s         = rx_clk_r + ONE_CLK;
        rx_bit_next_s         = rx_bit_r;
        rx_shift_next_s       = rx_shift_r;
        rx_push_s             = 1'b0;
        rx_frame_error_next_s = 1'b0;
        rx_overrun_set_s      = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_clk_next_s = ZERO_CLK;
                if (!rx_line_s) begin
                    rx_state_next_s = RX_START;
                end else begin
                    rx_state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_clk_r == HALF_LAST) begin
                    rx_clk_next_s = ZERO_CLK;
                    // A line already back high mid start bit is a glitch.
                    if (rx_line_s) begin
                        rx_state_next_s = RX_IDLE;
                    end else begin
                        rx_bit_next_s   = 3'd0;
                        rx_state_next_s = RX_DATA;
                    end
                end else begin
                    rx_state_next_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_clk_r == BIT_LAST) begin
                    rx_clk_next_s   = ZERO_CLK;
                    rx_shift_next_s = {rx_line_s, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_next_s = RX_STOP;
                    end else begin
                        rx_bit_next_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_state_next_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_clk_r == BIT_LAST) begin
                    rx_clk_next_s = ZERO_CLK;
                    if (rx_line_s) begin
                        rx_state_next_s = RX_IDLE;
                        if (rx_full_s) begin
                            rx_overrun_set_s = 1'b1;
                        end else begin
                            rx_push_s = 1'b1;
                        end
                    end else begin
                        rx_frame_error_next_s = 1'b1;
                        rx_state_next_s       = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_state_next_s = RX_STOP;
                end
            end
            RX_WAIT_HIGH: begin
                rx_clk_next_s = ZERO_CLK;
                if (rx_line_s) begin
                    rx_state_next_s = RX_IDLE;
                end else begin
                    rx_state_next_s = RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_clk_next_s   = ZERO_CLK;
                rx_state_next_s = RX_IDLE;
            end
        endcase
    end

    // RX FSM state, counters, shifter and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_r       <= RX_IDLE;
            rx_clk_r         <= ZERO_CLK;
            rx_bit_r         <= 3'd0;
            rx_shift_r       <= 8'h00;
            rx_frame_error_r <= 1'b0;
            rx_overrun_r     <= 1'b0;
        end else begin
            rx_state_r       <= rx_state_next_s;
            rx_clk_r         <= rx_clk_next_s;
            rx_bit_r         <= rx_bit_next_s;
            rx_shift_r       <= rx_shift_next_s;
            rx_frame_error_r <= rx_frame_error_next_s;
            rx_overrun_r     <= rx_overrun_r | rx_overrun_set_s;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr_r;
    logic [PTR_W-1:0] rx_rd_ptr_r;
    logic [PTR_W-1:0] rx_rd_ptr_next_s;
    logic [CNT_W-1:0] rx_count_next_s;
    logic             rx_valid_r;
    logic [7:0]       rx_data_r;
    logic [7:0]       rx_data_next_s;
    logic             rx_head_bypass_s;

    // RX occupancy and read pointer after this cycle's push/pop.
    always_comb begin
        rx_count_next_s  = rx_count_r;
        rx_rd_ptr_next_s = rx_rd_ptr_r;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_next_s = rx_count_r + ONE_CNT;
            2'b01:   rx_count_next_s = rx_count_r - ONE_CNT;
            default: rx_count_next_s = rx_count_r;
        endcase
        if (rx_pop_s) begin
            rx_rd_ptr_next_s = rx_rd_ptr_r + ONE_PTR;
        end else begin
            rx_rd_ptr_next_s = rx_rd_ptr_r;
        end
    end

    // The pushed byte becomes the head when nothing older remains after the pop.
    assign rx_head_bypass_s = rx_push_s &
                              ((rx_count_r == ZERO_CNT) |
                               ((rx_count_r == ONE_CNT) & rx_pop_s));

    // Next head value; holds the last byte once the FIFO drains.
    always_comb begin
        rx_data_next_s = rx_data_r;
        if (rx_head_bypass_s) begin
            rx_data_next_s = rx_shift_r;
        end else if (rx_count_next_s != ZERO_CNT) begin
            rx_data_next_s = rx_mem_r[rx_rd_ptr_next_s];
        end else begin
            rx_data_next_s = rx_data_r;
        end
    end

    // RX FIFO storage, pointers, count and registered head/valid outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_r[i] <= 8'h00;
            end
            rx_wr_ptr_r <= ZERO_PTR;
            rx_rd_ptr_r <= ZERO_PTR;
            rx_count_r  <= ZERO_CNT;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= 8'h00;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
                rx_wr_ptr_r           <= rx_wr_ptr_r + ONE_PTR;
            end
            rx_rd_ptr_r <= rx_rd_ptr_next_s;
            rx_count_r  <= rx_count_next_s;
            rx_valid_r  <= (rx_count_next_s != ZERO_CNT);
            rx_data_r   <= rx_data_next_s;
        end
    end

    assign cpu_tx_ready   = tx_ready_r;
    assign uart_txd       = txd_r;
    assign cpu_rx_data    = rx_data_r;
    assign cpu_rx_valid   = rx_valid_r;
    assign rx_overrun     = rx_overrun_r;
    assign rx_frame_error = rx_frame_error_r;

endmodule

// File: tb/tb_uart_serial_bridge.sv
// Directed self-checking bench for uart_serial_bridge (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A negedge line monitor decodes uart_txd frames into a queue; expected bytes
// are queued when stimulus is driven and compared when frames/reads appear.

module tb_uart_serial_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_tx_data = 8'h00;
    logic       cpu_tx_wren = 1'b0;
    logic       cpu_tx_ready;
    logic [7:0] cpu_rx_data;
    logic       cpu_rx_valid;
    logic       cpu_rx_rden = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;
    logic       rx_overrun;
    logic       rx_frame_error;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int fe_cnt     = 0;

    typedef struct {
        logic [7:0] d;
        logic       start_b;
        logic       stop_b;
        int         start_cyc;
        logic       rdy;
    } frame_t;

    frame_t     mon_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       exp_overrun = 1'b0;

    uart_serial_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_tx_data    (cpu_tx_data),
        .cpu_tx_wren    (cpu_tx_wren),
        .cpu_tx_ready   (cpu_tx_ready),
        .cpu_rx_data    (cpu_rx_data),
        .cpu_rx_valid   (cpu_rx_valid),
        .cpu_rx_rden    (cpu_rx_rden),
        .uart_rxd       (uart_rxd),
        .uart_txd       (uart_txd),
        .rx_overrun     (rx_overrun),
        .rx_frame_error (rx_frame_error)
    );

    always #5 clock = ~clock;

    // Cycle counter used to time frame starts.
    always @(posedge clock) cyc <= cyc + 1;

    // Count frame-error pulses, sampled away from the active edge.
    always @(negedge clock) if (rx_frame_error === 1'b1) fe_cnt <= fe_cnt + 1;

    // Line monitor: detect start bit, sample each bit at its middle.
    logic       mon_busy = 1'b0;
    int         mon_cnt  = 0;
    int         mon_start = 0;
    logic       mon_rdy  = 1'b0;
    logic [9:0] mon_sh   = 10'h000;

    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (uart_txd === 1'b0) begin
                mon_busy  <= 1'b1;
                mon_cnt   <= 1;
                mon_start <= cyc;
                mon_rdy   <= cpu_tx_ready;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt % CPB) == (CPB / 2)) mon_sh[mon_cnt / CPB] <= uart_txd;
            if (mon_cnt == 10 * CPB - 1) begin
                mon_q.push_back('{d: mon_sh[8:1], start_b: mon_sh[0], stop_b: mon_sh[9],
                                  start_cyc: mon_start, rdy: mon_rdy});
                mon_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        cpu_tx_data = d;
        cpu_tx_wren = 1'b1;
        @(negedge clock);
        cpu_tx_wren = 1'b0;
    endtask

    task automatic get_frame(output frame_t f, output logic got);
        for (int t = 0; t < 400 && mon_q.size() == 0; t++) @(negedge clock);
        got = (mon_q.size() != 0);
        if (got) f = mon_q.pop_front();
        else f = '{d: 8'h00, start_b: 1'b1, stop_b: 1'b0, start_cyc: 0, rdy: 1'b0};
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_b);
        if (stop_b) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(d);
            else exp_overrun = 1'b1;
        end
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int b = 0; b < 8; b++) begin
            uart_rxd = d[b];
            repeat (CPB) @(negedge clock);
        end
        uart_rxd = stop_b;
        repeat (CPB) @(negedge clock);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int t = 0; t < 30 && cpu_rx_valid !== 1'b1; t++) @(negedge clock);
        check(tag, cpu_rx_valid, 1'b1);
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] e;
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
        check({tag, "_valid"}, cpu_rx_valid, 1'b1);
        check({tag, "_data"}, cpu_rx_data, e);
        cpu_rx_rden = 1'b1;
        @(negedge clock);
        cpu_rx_rden = 1'b0;
    endtask

    initial begin
        frame_t     f;
        logic       got;
        logic [9:0] fr;
        logic [7:0] e;
        int         prev_start;
        int         fe0;
        logic       low_seen;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_ready", cpu_tx_ready, 1'b1);
        check("rst_valid", cpu_rx_valid, 1'b0);
        check("rst_rxdata", cpu_rx_data, 8'h00);
        check("rst_overrun", rx_overrun, 1'b0);
        check("rst_ferr", rx_frame_error, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // 1: single byte 0xA5, cycle-exact line shape
        tx_q.push_back(8'hA5);
        tx_write(8'hA5);
        check("t1_pre", uart_txd, 1'b1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clock);
            check($sformatf("t1_cyc%0d", i), uart_txd, fr[i / CPB]);
        end
        @(negedge clock);
        check("t1_idle", uart_txd, 1'b1);
        check("t1_ready", cpu_tx_ready, 1'b1);
        get_frame(f, got);
        check("t1_got", got, 1'b1);
        e = tx_q.pop_front();
        check("t1_byte", f.d, e);
        repeat (4) @(negedge clock);

        // 2: burst 0x01..0x06, 0x06 dropped, frames back-to-back
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) check("t2_ready_before_full", cpu_tx_ready, 1'b1);
            if (k == 6) check("t2_ready_full", cpu_tx_ready, 1'b0);
            if (k <= 5) tx_q.push_back(8'(k));
            cpu_tx_data = 8'(k);
            cpu_tx_wren = 1'b1;
            @(negedge clock);
        end
        cpu_tx_wren = 1'b0;
        check("t2_ready_busy", cpu_tx_ready, 1'b0);
        prev_start = 0;
        for (int k = 0; k < 5; k++) begin
            get_frame(f, got);
            check($sformatf("t2_got%0d", k), got, 1'b1);
            e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
            check($sformatf("t2_byte%0d", k), f.d, e);
            check($sformatf("t2_stop%0d", k), f.stop_b, 1'b1);
            if (k > 0) check($sformatf("t2_gap%0d", k), f.start_cyc, prev_start + 10 * CPB);
            if (k == 1) check("t2_ready_back", f.rdy, 1'b1);
            prev_start = f.start_cyc;
        end
        repeat (80) @(negedge clock);
        check("t2_no_extra", mon_q.size(), 0);
        check("t2_idle", uart_txd, 1'b1);

        // 3: RX single frame 0x3C then pop
        send_rx(8'h3C, 1'b1);
        wait_valid("t3_wait");
        rx_read("t3");
        check("t3_empty", cpu_rx_valid, 1'b0);

        // 4: five frames without reading -> overrun, four in order
        for (int k = 0; k < 5; k++) begin
            send_rx(8'h10 + 8'(k), 1'b1);
            if (k == 3) begin
                repeat (6) @(negedge clock);
                check("t4_no_overrun_yet", rx_overrun, 1'b0);
            end
        end
        repeat (6) @(negedge clock);
        check("t4_overrun", rx_overrun, exp_overrun);
        for (int k = 0; k < 4; k++) rx_read($sformatf("t4_rd%0d", k));
        check("t4_empty", cpu_rx_valid, 1'b0);
        check("t4_rx_hold", cpu_rx_data, 8'h13);

        // 5: bad stop bit, then an idle glitch
        fe0 = fe_cnt;
        send_rx(8'h55, 1'b0);
        repeat (8) @(negedge clock);
        check("t5_ferr_pulses", fe_cnt - fe0, 1);
        check("t5_no_push", cpu_rx_valid, 1'b0);
        fe0 = fe_cnt;
        uart_rxd = 1'b0;
        @(negedge clock);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clock);
        check("t5_glitch_ferr", fe_cnt - fe0, 0);
        check("t5_glitch_valid", cpu_rx_valid, 1'b0);
        check("t5_overrun_sticky", rx_overrun, 1'b1);

        // 6: reset in the middle of bit 3 of 0xFF
        tx_write(8'hFF);
        for (int t = 0; t < 20 && uart_txd !== 1'b0; t++) @(negedge clock);
        check("t6_started", uart_txd, 1'b0);
        repeat (18) @(negedge clock);
        check("t6_busy_ready", cpu_tx_ready, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_rst_txd", uart_txd, 1'b1);
        check("t6_rst_ready", cpu_tx_ready, 1'b1);
        check("t6_rst_overrun", rx_overrun, 1'b0);
        check("t6_rst_valid", cpu_rx_valid, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        mon_q.delete();
        low_seen = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clock);
            if (uart_txd !== 1'b1) low_seen = 1'b1;
        end
        check("t6_no_frame", low_seen, 1'b0);
        check("t6_no_mon", mon_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_serial_bridge.md
Name: uart_serial_bridge

Overview:
- Sits directly downstream of the processor's serial port. Converts its byte-wide serial handshake into an 8N1 UART line pair.
- TX side: accepts bytes on a one-cycle write strobe, buffers them in a FIFO and shifts them out on uart_txd.
- RX side: deserialises uart_rxd into a show-ahead FIFO that the processor pops on a read strobe.
- Processor-side ports map one-to-one onto serial_out / serial_wren_out / serial_ready_in / serial_in / serial_valid_in / serial_rden_out.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit; minimum 4.
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of 2, minimum 2.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cpu_tx_data  input  8  byte to transmit (from serial_out).
cpu_tx_wren  input  1  one-cycle write strobe (from serial_wren_out).
cpu_tx_ready  output  1  TX FIFO not full (to serial_ready_in).
cpu_rx_data  output  8  head of RX FIFO, show-ahead (to serial_in).
cpu_rx_valid  output  1  RX FIFO not empty (to serial_valid_in).
cpu_rx_rden  input  1  pop strobe for RX FIFO (from serial_rden_out).
uart_rxd  input  1  asynchronous serial input line.
uart_txd  output  1  serial output line, idle high.
rx_overrun  output  1  sticky: a received byte was dropped because the RX FIFO was full.
rx_frame_error  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset (asynchronous, reset=0):
  - uart_txd=1, cpu_tx_ready=1, cpu_rx_valid=0, cpu_rx_data=0, rx_overrun=0, rx_frame_error=0.
  - Both FIFOs are emptied and both FSMs go to IDLE.
  - The RX synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame immediately. No partial byte is kept.
- All outputs are registered.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- TX FIFO:
  - A write happens when cpu_tx_wren=1 and cpu_tx_ready=1. A wren while ready=0 is dropped silently; FIFO contents are not disturbed.
  - cpu_tx_ready is derived from the registered occupancy count.
  - A push and pop in the same cycle leave the count unchanged.
- TX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: if the FIFO is non-empty (registered count>0), pop the head into the shift register and enter START on the next cycle, driving uart_txd=0.
  - DATA: 8 bits, bit counter 0..7.
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles. At STOP end, a non-empty FIFO pops and goes straight to START, so there is no idle gap between frames. Otherwise the FSM returns to IDLE.
- RX synchronisation: uart_rxd passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> STOP (plus WAIT_HIGH).
  - IDLE: synchronised line = 0 enters START.
  - START: wait CLKS_PER_BIT/2 (floor) cycles, then resample. If 1, treat as a glitch and return to IDLE. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 samples.
  - STOP: sample one bit later.
    - Sample 1 with FIFO not full: push the byte.
    - Sample 1 with FIFO full: drop the byte and set rx_overrun (held until reset).
    - Sample 0: pulse rx_frame_error for one cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line = 1, then go to IDLE.
- RX latency: cpu_rx_valid rises the cycle after the stop-bit sample cycle.
- RX FIFO read rules:
  - cpu_rx_rden with cpu_rx_valid=1 pops; cpu_rx_data shows the next entry (or holds its last value if the FIFO is now empty) on the following cycle.
  - cpu_rx_rden while empty is ignored.
  - A push and pop in the same cycle on a full FIFO both take effect, with no overrun.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Test Plan:
(CLKS_PER_BIT=4, FIFO_DEPTH=4)
1. Reset, then write 0xA5 -> uart_txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; 40 cycles total; line idle high afterwards.
2. From idle, write 0x01..0x06 on consecutive cycles -> 0x01 goes to the shifter and 0x02–0x05 fill the FIFO. cpu_tx_ready is low in the 0x06 cycle, so 0x06 is dropped. The line carries 01..05 back-to-back in 200 cycles, and ready returns high when 0x02 pops.
3. Drive an RX frame of 0x3C -> cpu_rx_valid=1 with cpu_rx_data=0x3C. Pulse rden -> valid=0 the next cycle.
4. Send 5 RX frames 0x10..0x14 without reading -> rx_overrun=1 after the 5th. Four reads return 0x10..0x13 in order, then valid=0.
5. RX frame with stop bit 0 -> one rx_frame_error pulse and no push. Then a 1-cycle low glitch in idle -> no byte and no error.
6. Assert reset mid-TX (bit 3 of 0xFF) -> uart_txd=1 immediately, ready=1, and no further frame after release.
